// File: rtl/mux8way_rr_collector_pkg.sv
// Shared constants and helpers for the 8-lane mux/dmux family.
// Lane i occupies bits [lane_slice(i, width) +: width] of a packed lane bus.
package mux8way_rr_collector_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  function automatic int lane_slice(input int i, input int width);
    return i * width;
  endfunction

endpackage

// File: rtl/mux8way_rr_collector_dmux8way.sv
// 1-to-8 demultiplexer: routes 'in' onto output bit 'sel', all others low.
module DMux8Way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic [7:0] out
);

  always_comb begin
    out      = '0;
    out[sel] = in;
  end

endmodule

// File: rtl/mux8way_rr_collector_rr_pick8.sv
// Combinational round-robin picker: first set request after 'last', wrapping mod 8.
module rr_pick8
  import mux8way_rr_collector_pkg::*;
(
  input  logic [LANES-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [2*LANES-1:0] dbl;
  logic [LANES-1:0]   rot;
  logic [SEL_W-1:0]   start;
  logic [SEL_W-1:0]   off;

  // Rotate the request vector so the lane just after 'last' sits at bit 0,
  // then take the lowest set bit; 3-bit arithmetic gives the mod-8 wrap.
  always_comb begin
    start = last + SEL_W'(1);
    dbl   = {req, req};
    rot   = dbl[start +: LANES];
    off   = '0;
    for (int j = LANES - 1; j >= 0; j--) begin
      if (rot[j]) off = SEL_W'(j);
    end
    idx = start + off;
    any = |req;
  end

endmodule

// File: rtl/mux8way_rr_collector.sv
// Merges 8 valid/ready lanes into one registered stream with round-robin
// arbitration; each output word is tagged with its source lane index.
module mux8way_rr_collector #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  input  logic               out_ready
);

  import mux8way_rr_collector_pkg::*;

  logic             load;
  logic             any;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] last;

  assign load = !out_valid || out_ready;

  rr_pick8 u_pick (
    .req  (in_valid),
    .last (last),
    .any  (any),
    .idx  (idx)
  );

  DMux8Way u_grant (
    .in  (load & any),
    .sel (idx),
    .out (in_ready)
  );

  // The output register only moves when empty or being drained; data is
  // loaded solely from the granted lane so ungranted lanes never leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= SEL_W'(LANES - 1);
    end else if (load) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= in_data[lane_slice(int'(idx), WIDTH) +: WIDTH];
        out_sel   <= idx;
        last      <= idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mux8way_rr_collector.md
Name: mux8way_rr_collector

Overview:
- Collector at the merge side of an 8-lane fan-out.
- Takes 8 independent valid/ready input lanes and merges them into one registered valid/ready output stream.
- Arbitration is fair round-robin; each output word carries the 3-bit index of its source lane.
- Sits downstream of DMux8Way-style routing, so lane traffic rejoins a single channel without reordering within a lane.

Parameters:
- WIDTH, 16, data bits per lane and on the output.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  8  per-lane valid; bit i belongs to lane i
- in_data  input  8*WIDTH  lane i data at bits [i*WIDTH +: WIDTH]
- in_ready  output  8  per-lane ready, one-hot or zero
- out_valid  output  1  output word present
- out_data  output  WIDTH  output word
- out_sel  output  3  source lane index of out_data
- out_ready  input  1  downstream accepts the word

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - rst_n asserted (low) immediately clears out_valid=0, out_data=0, out_sel=0, and round-robin pointer last=7, so lane 0 has top priority after reset.
  - Release is taken synchronously at the next clk edge.
- Output register:
  - load = !out_valid | out_ready, meaning the register is empty or is being drained this cycle.
- Arbitration (combinational, every cycle):
  - If load=1 and any in_valid bit is set, pick winner w = the first i with in_valid[i]=1, searching last+1, last+2, … mod 8.
  - in_ready = one-hot(w) when load=1 and a request exists; otherwise in_ready=0.
  - in_ready may depend on in_valid. Lanes must not make in_valid depend on in_ready.
- Transfer on a clk edge:
  - Lane transfer occurs when in_valid[w] & in_ready[w].
  - On transfer: out_data <= lane w data, out_sel <= w, out_valid <= 1, last <= w.
  - Latency is 1 cycle from lane acceptance to out_valid.
- Drain without refill: out_valid & out_ready and no request -> out_valid <= 0. out_data and out_sel hold their last values.
- Stall: out_valid=1 & out_ready=0 -> in_ready=0. out_data, out_sel and last stay stable until accepted.
- Simultaneous drain and refill: the new word loads in the same edge, giving throughput of 1 word/cycle with no bubble.
- Fairness: a lane that stays valid is granted within 8 transfers. Pointer wrap 7 -> 0 is modulo 8.
- No requests: last is unchanged, so priority is not reset by idle cycles.
- Reset mid-transfer: the pending output word is dropped and no lane sees acceptance on that edge.
- No X propagation: out_data is never loaded from a lane that was not granted.

Decomposition:
- Shared package, also used by the dmux8way family:
  - LANES=8
  - SEL_W=3
  - function lane_slice(i) returning the bit offset i*WIDTH
- Sub-module rr_pick8, combinational:
  - inputs: req[7:0], last[2:0]
  - outputs: any, idx[2:0]
- in_ready is produced by instantiating the existing DMux8Way with in=load&any and sel=idx.

Test Plan:
1. Reset then single lane:
   - Stimulus: hold rst_n=0 for 2 cycles, release; in_valid=8'h08, lane 3 data=16'hBEEF, out_ready=1.
   - Required: in_ready=8'h08 in the same cycle; next cycle out_valid=1, out_data=16'hBEEF, out_sel=3.
2. Round-robin all lanes:
   - Stimulus: in_valid=8'hFF continuously, lane i data=16'h0100+i, out_ready=1.
   - Required: out_sel sequence 0,1,…,7,0 on consecutive cycles; out_data 16'h0100 through 16'h0107; no bubbles.
3. Backpressure:
   - Stimulus: after out_valid=1 with out_sel=2, drive out_ready=0 for 5 cycles.
   - Required: in_ready=0 and out_data/out_sel stable throughout; first out_ready=1 cycle drains and loads the next lane (4 if in_valid=8'h14).
4. Pointer wrap and skip:
   - Stimulus: last=7 after granting lane 7; in_valid=8'h42.
   - Required: grant order lane 1, then lane 6, then lane 1.
5. Idle drain:
   - Stimulus: one word from lane 5, then in_valid=0, out_ready=1.
   - Required: out_valid falls after one cycle; out_sel stays 5; the next request from lane 0 (in_valid=8'h01) is granted with no extra delay.
6. Async reset mid-stall:
   - Stimulus: out_valid=1, out_ready=0; pulse rst_n low between clock edges.
   - Required: out_valid=0, out_data=0, out_sel=0 immediately; after release, in_valid=8'h81 grants lane 0 first.
